// File: rtl/axis_chsel_pfb_pkg.sv
// Shared constants and state type for the PFB channel selector.
// Frame geometry: N_CH channels delivered as BEATS beats of L 32-bit lanes.
package axis_chsel_pfb_pkg;

    localparam int N_CH   = 64;
    localparam int L      = 8;
    localparam int BEATS  = N_CH / L;
    localparam int LANE_W = 32;

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/pfb_frame_tracker.sv
// Frame alignment tracker: follows tlast to keep a beat index within the
// PFB frame and flags framing errors (early or missing tlast).
module pfb_frame_tracker
    import axis_chsel_pfb_pkg::*;
#(
    parameter int BEATS = axis_chsel_pfb_pkg::BEATS,
    localparam int BW   = $clog2(BEATS)
) (
    input  logic          aclk,
    input  logic          areset,
    input  logic          tvalid,
    input  logic          tlast,
    output logic [BW-1:0] beat,
    output logic          locked,
    output logic          err_set
);

    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [BW-1:0]   r_beat;
    logic [BW-1:0]   w_beat_nxt;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= SYNC;
            r_beat  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
        end
    end

    // An early tlast realigns in place; a missing tlast means alignment is lost.
    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        err_set     = 1'b0;
        case (r_state)
            SYNC: begin
                if (tvalid && tlast) begin
                    w_state_nxt = RUN;
                    w_beat_nxt  = '0;
                end
            end
            RUN: begin
                if (tvalid) begin
                    if (r_beat == LAST_BEAT) begin
                        w_beat_nxt = '0;
                        if (!tlast) begin
                            err_set     = 1'b1;
                            w_state_nxt = SYNC;
                        end
                    end else if (tlast) begin
                        err_set    = 1'b1;
                        w_beat_nxt = '0;
                    end else begin
                        w_beat_nxt = r_beat + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = SYNC;
                w_beat_nxt  = '0;
            end
        endcase
    end

    assign beat   = r_beat;
    assign locked = (r_state == RUN);

endmodule

// File: rtl/axis_chsel_pfb_8x64.sv
// Selects one channel out of each PFB frame and emits it as a single
// registered {Q,I} sample, one cycle after its beat arrives.
module axis_chsel_pfb_8x64
    import axis_chsel_pfb_pkg::*;
#(
    parameter int N_CH = axis_chsel_pfb_pkg::N_CH,
    parameter int L    = axis_chsel_pfb_pkg::L
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic                       s_axis_tvalid,
    input  logic                       s_axis_tlast,
    input  logic [LANE_W*L-1:0]        s_axis_tdata,
    input  logic [$clog2(N_CH)-1:0]    chsel,
    input  logic                       err_clr,
    output logic                       m_axis_tvalid,
    output logic [LANE_W-1:0]          m_axis_tdata,
    output logic [$clog2(N_CH)-1:0]    m_axis_tuser,
    output logic                       locked,
    output logic                       err
);

    localparam int BEATS_P   = N_CH / L;
    localparam int BEAT_W    = $clog2(BEATS_P);
    localparam int LANE_BITS = $clog2(L);
    localparam int CH_W      = $clog2(N_CH);

    logic [L-1:0][LANE_W-1:0] w_lanes;
    logic [BEAT_W-1:0]        w_beat;
    logic                     w_locked;
    logic                     w_err_set;
    logic                     w_sel;

    logic [CH_W-1:0]          r_chsel;
    logic                     r_tvalid;
    logic [LANE_W-1:0]        r_tdata;
    logic [CH_W-1:0]          r_tuser;
    logic                     r_err;

    pfb_frame_tracker #(
        .BEATS (BEATS_P)
    ) u_tracker (
        .aclk    (aclk),
        .areset  (areset),
        .tvalid  (s_axis_tvalid),
        .tlast   (s_axis_tlast),
        .beat    (w_beat),
        .locked  (w_locked),
        .err_set (w_err_set)
    );

    assign w_lanes = s_axis_tdata;
    assign w_sel   = w_locked && s_axis_tvalid
                     && (w_beat == r_chsel[CH_W-1:LANE_BITS]);

    // Selection is compared against the value latched at the previous tlast,
    // so a chsel change can only take effect on a frame boundary.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_chsel  <= '0;
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_tuser  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_tvalid <= w_sel;
            if (w_sel) begin
                r_tdata <= w_lanes[r_chsel[LANE_BITS-1:0]];
                r_tuser <= r_chsel;
            end
            if (s_axis_tvalid && s_axis_tlast) begin
                r_chsel <= chsel;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tuser  = r_tuser;
    assign locked        = w_locked;
    assign err           = r_err;

endmodule

// File: doc/axis_chsel_pfb_8x64.md
AXIS_CHSEL_PFB_8X64 -- requirements
Module: axis_chsel_pfb_8x64

Interface
REQ-001 SHALL have parameter N_CH, default 64, meaning channels per PFB frame.
REQ-002 SHALL have parameter L, default 8, meaning 32-bit lanes per input beat; beats per frame = N_CH/L = 8.
REQ-003 SHALL have port aclk, input, 1, the single clock for all logic.
REQ-004 SHALL have port areset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port s_axis_tvalid, input, 1, input beat valid; there is no tready.
REQ-006 SHALL have port s_axis_tlast, input, 1, marks the last beat of a frame.
REQ-007 SHALL have port s_axis_tdata, input, 32*L, lane k is bits [32k+31:32k], with I in [15:0] and Q in [31:16].
REQ-008 SHALL have port chsel, input, 6, requested channel index 0..63.
REQ-009 SHALL have port err_clr, input, 1, single-cycle pulse that clears err.
REQ-010 SHALL have port m_axis_tvalid, output, 1, selected sample valid.
REQ-011 SHALL have port m_axis_tdata, output, 32, selected {Q,I} sample.
REQ-012 SHALL have port m_axis_tuser, output, 6, channel index of the current m_axis_tdata.
REQ-013 SHALL have port locked, output, 1, frame alignment acquired.
REQ-014 SHALL have port err, output, 1, sticky framing error.

Function
REQ-015 SHALL map channel c to beat c/L (c[5:3]) and lane c%L (c[2:0]).
REQ-016 SHALL implement two states: SYNC and RUN.
REQ-017 SYNC SHALL ignore data; on s_axis_tvalid && s_axis_tlast, set beat counter to 0 and go to RUN.
REQ-018 In RUN, the 3-bit beat counter SHALL advance only on s_axis_tvalid; cycles without tvalid hold all state.
REQ-019 In RUN, a valid beat with counter==7 and tlast=1 SHALL wrap the counter to 0, which is normal operation.
REQ-020 In RUN, a valid beat with counter==7 and tlast=0 SHALL set err and go to SYNC.
REQ-021 In RUN, a valid beat with counter<7 and tlast=1 SHALL set err, reset the counter to 0, and stay in RUN (realign).
REQ-022 locked SHALL be 1 exactly while the state is RUN.
REQ-023 chsel SHALL be sampled into chsel_r only on a valid tlast beat (in either state), so a selection change never takes effect mid-frame.
REQ-024 In RUN, a valid beat whose counter equals chsel_r[5:3] SHALL produce m_axis_tvalid=1 for exactly one cycle, on the following cycle.
REQ-025 That output cycle SHALL carry m_axis_tdata = lane chsel_r[2:0] of that beat and m_axis_tuser = chsel_r.
REQ-026 Latency from the selected beat to m_axis_tvalid SHALL be exactly 1 aclk cycle.
REQ-027 At most one output SHALL occur per frame; m_axis_tdata and m_axis_tuser hold their value between outputs.
REQ-028 A beat that raises an error (REQ-020/021) SHALL still produce output if it is the selected beat; later frames follow the new alignment.
REQ-029 err SHALL be set by any framing error and cleared only by err_clr or reset.
REQ-030 When err_clr coincides with a new error, set SHALL win.
REQ-031 Data SHALL pass through unmodified: no rounding, no sign handling, no arithmetic.

Reset
REQ-032 areset SHALL asynchronously force: state=SYNC, counter=0, chsel_r=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, locked=0, err=0.
REQ-033 Reset asserted mid-frame SHALL discard the partial frame; after release the block waits in SYNC for the next tlast.

Structure
REQ-034 A shared package axis_chsel_pfb_pkg SHALL hold N_CH, L, BEATS=N_CH/L, the constant lane width 32, and the state enum {SYNC, RUN}.
REQ-035 The state machine and beat counter SHALL live in one sub-module, pfb_frame_tracker (outputs: beat, locked, err_set); the lane mux and output registers stay in the top module.

Verification
REQ-036 Continuous valid frames with lane value {beat,lane} encoded and chsel=19 -> after the first tlast, one output per frame carrying the beat-2/lane-3 value, tuser=19, 1 cycle after beat 2; err=0.
REQ-037 tvalid deasserted for 3 cycles mid-frame -> beat counting pauses, the output value is unchanged, and the output is delayed by the 3 gap cycles.
REQ-038 chsel changed from 5 to 60 at beat 3 -> the current frame still outputs channel 5; the next frame outputs channel 60 (beat 7, lane 4).
REQ-039 tlast at beat 4 -> err=1 and locked stays 1; the counter realigns and the next 8-beat frame outputs correctly; err_clr -> err=0.
REQ-040 tlast missing at beat 7 -> err=1 and locked=0; no outputs until the next tlast, then relock.
REQ-041 areset pulsed mid-frame -> all outputs 0 immediately (asynchronously); no output until a tlast is seen and the next frame's selected beat arrives.
